ins_fetch: RTL and testbench
============================

# ins_fetch

Instruction fetch front-end that drives the instruction buffer's PC input and consumes its registered instruction output. Generates sequential fetch addresses, pairs each returned instruction with its PC, and queues the pairs for decode behind a valid/ready handshake. Accepts a redirect from execute (branch/jump) that flushes all in-flight and queued fetches.

## Interface
- `RESET_PC`, default 32'h0: fetch address after reset.
- `PC_STEP`, default 1: PC increment per instruction; the instruction buffer indexes in word units.
- `QDEPTH`, default 2: queue entries, power of two, ≥2.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `fetch_pc`  out  32  registered fetch address; drives instruction buffer `pc_in`
- `ins_in`  in  32  instruction buffer `ins_out`; holds the word for the `fetch_pc` presented in the previous cycle
- `redirect_valid`  in  1  redirect request, single-cycle pulse or held
- `redirect_pc`  in  32  redirect target
- `out_valid`  out  1  queue head valid
- `out_ready`  in  1  decode accepts head
- `out_pc`  out  32  PC of head instruction
- `out_ins`  out  32  head instruction

## Operation
- State: `fetch_pc` reg, `inflight` bit, `req_pc` reg, queue with `count` (width clog2(QDEPTH)+1).
- pop = out_valid & out_ready.
- issue = !redirect_valid & ((count + inflight - pop) < QDEPTH).
- On issue: `req_pc` <= `fetch_pc`; `inflight` <= 1; `fetch_pc` <= `fetch_pc` + PC_STEP (32-bit, wraps modulo 2^32). Otherwise `inflight` <= 0 and `fetch_pc` holds.
- When `inflight`=1 and no redirect: push {`req_pc`, `ins_in`} at the queue tail. The credit rule guarantees a push never finds the queue full. Push and pop in the same cycle are both performed, and `count` is unchanged.
- Redirect has priority over all other actions: `fetch_pc` <= `redirect_pc`, `inflight` <= 0, and the queue is emptied (`count` <= 0, pointers <= 0). An in-flight `ins_in` is discarded. A pop in the redirect cycle still counts as accepted by decode.
- `ins_in` is ignored whenever `inflight`=0. Its contents are opaque; no decoding is done here.
- Outputs are driven from the head entry. When the queue is empty: `out_valid`=0, `out_pc`=0, `out_ins`=32'h00000013 (NOP).
- Holding `out_ready` low is legal; the head entry stays stable until it is popped or flushed.

## Timing
- Reset values: `fetch_pc`=RESET_PC, `inflight`=0, queue empty. Hence `out_valid`=0, `out_pc`=0, `out_ins`=NOP.
- Let cycle 0 be the first cycle with `rst`=0. `fetch_pc`=RESET_PC is issued in cycle 0, pushed at the end of cycle 1, and seen as `out_valid`=1 in cycle 2. Fetch-to-decode latency is 2 cycles.
- With `out_ready` held at 1, throughput is one instruction per cycle, and `out_pc` increments by PC_STEP each cycle.
- Redirect asserted in cycle N: `fetch_pc`=redirect_pc in cycle N+1, `out_valid`=0 in cycle N+1, and the first redirected instruction appears in cycle N+3.
- Back-pressure: with `out_ready`=0 the queue fills. At most QDEPTH entries are held, `fetch_pc` stops advancing, and no instruction is dropped or duplicated.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of `redirect_valid`.

## Structure
- Shared package `scpu_fetch_pkg`: `NOP_INS` = 32'h00000013, `XLEN` = 32, and a fetch-entry struct {pc, ins}.
- Sub-module `fetch_queue`: circular FIFO with parameter QDEPTH and ports push, pop, flush, count, head. Flush has priority over push.
- `ins_fetch` contains the PC register, the in-flight tracking and the credit logic.

## Test plan
- Reset then `out_ready`=1 with RESET_PC=0: `out_valid` rises in cycle 2, and `out_pc` is 0,1,2,3… on consecutive cycles with `out_ins` equal to the model word for each PC.
- `out_ready`=0 for 10 cycles: `count` saturates at QDEPTH and `fetch_pc` freezes. On release, PCs continue contiguously with no gap or repeat.
- Redirect to 32'h8 in cycle 5 with a full queue: `out_valid`=0 in cycle 6, the next output has `out_pc`=8 in cycle 8, and no stale PC appears.
- Redirect together with `out_ready`=1 and a valid head: the head is consumed once, the queue is flushed, and the next output is the redirect target.
- Back-to-back redirects in cycles 5 and 6 (targets 4, then 9): only 9 and its successors reach the output.
- Set `fetch_pc` to 32'hFFFFFFFF with PC_STEP=1: the next `out_pc` after 32'hFFFFFFFF is 32'h0. Asserting `rst` mid-stream returns `out_valid`=0 and `out_ins`=NOP on the next cycle.

Source files
------------

// File: rtl/scpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scpu_fetch_pkg
// Purpose  : Shared constants and types for the instruction fetch front-end.
//            XLEN       - datapath width
//            NOP_INS    - word presented to decode when nothing is queued
//            fetch_entry_t - one queued {pc, ins} pair
// Revision : 1.0 - initial release
// ============================================================================
package scpu_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INS = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular FIFO of fetch entries. Flush empties the queue and
//            resets both pointers; it takes priority over push and pop.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            push, push_entry - write an entry at the tail
//            pop              - drop the head entry (ignored when empty)
//            flush            - discard all entries
//            count            - number of held entries (0..QDEPTH)
//            head             - head entry (undefined when count == 0)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import scpu_fetch_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic do_push;
  logic do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ins_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetch
// Purpose  : Instruction fetch front-end. Issues sequential fetch addresses
//            to a registered instruction buffer, pairs each returned word
//            with its PC and queues the pairs for decode. A redirect flushes
//            everything in flight and restarts fetch at the target.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            fetch_pc                 - registered address to buffer pc_in
//            ins_in                   - buffer word for last cycle's fetch_pc
//            redirect_valid/_pc       - redirect request and target
//            out_valid/out_ready      - decode handshake on queue head
//            out_pc, out_ins          - head entry (0 / NOP when empty)
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetch
  import scpu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd1,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] ins_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_ins
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q,   req_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credit_used;

  assign pop = out_valid & out_ready;

  // Credit: slots already taken plus the word still in flight, minus the
  // slot freed this cycle. One extra bit keeps the sum from overflowing;
  // it cannot underflow because pop implies count >= 1.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q}
                     - {{CW{1'b0}}, pop};
  assign issue = ~redirect_valid & (credit_used < (CW+1)'(QDEPTH));

  // The returned word is only meaningful while a fetch is in flight;
  // a redirect discards it.
  assign push = inflight_q & ~redirect_valid;

  always_comb begin
    push_entry.pc  = req_pc_q;
    push_entry.ins = ins_in;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign fetch_pc  = fetch_pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc  : '0;
  assign out_ins   = out_valid ? head.ins : NOP_INS;

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_fetch
// Purpose  : Self-checking bench for ins_fetch. A registered instruction
//            buffer model feeds ins_in; directed scenarios push the expected
//            {pc, ins} stream into a scoreboard that a monitor drains on
//            every accepted output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] ins_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests;
  int   n_fail;
  int   cyc;

  ins_fetch #(
    .RESET_PC (32'h0),
    .PC_STEP  (32'd1),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .ins_in         (ins_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ins        (out_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Registered instruction buffer model.
  always @(posedge clk) ins_in <= ins_of(fetch_pc);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: start + 32'(i), ins: ins_of(start + 32'(i))});
    end
  endtask

  // Monitor: every accepted head must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h, want no output", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_out_pc", out_pc, mon_e.pc);
        check("sb_out_ins", out_ins, mon_e.ins);
      end
    end
  end

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_ins", out_ins, 32'h00000013);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Stop accepting, then confirm every expected output was seen.
  task automatic finish_scn();
    run_to(cyc + 1);
    out_ready = 1'b0;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;

    // Streaming from reset with decode always ready.
    do_reset(1'b1);
    push_exp(32'd0, 12);
    @(negedge clk); check("lat_c0_valid", 32'(out_valid), 32'd0);
    run_to(1); @(negedge clk); check("lat_c1_valid", 32'(out_valid), 32'd0);
    run_to(2); @(negedge clk); check("lat_c2_valid", 32'(out_valid), 32'd1);
    check("lat_c2_pc", out_pc, 32'd0);
    run_to(13);

    // Back-pressure: ready low for 10 cycles from cycle 14.
    run_to(14);
    out_ready = 1'b0;
    push_exp(32'd12, 8);
    run_to(16); @(negedge clk); check("bp_head_pc_c16", out_pc, 32'd12);
    run_to(23); @(negedge clk);
    check("bp_fetch_frozen", fetch_pc, 32'd14);
    check("bp_count_full", 32'(dut.count), 32'd2);
    check("bp_head_pc_c23", out_pc, 32'd12);
    check("bp_valid", 32'(out_valid), 32'd1);
    run_to(24);
    out_ready = 1'b1;
    run_to(26); @(negedge clk); check("bp_resume_pc", out_pc, 32'd14);
    run_to(31);
    finish_scn();

    // Redirect to 8 in cycle 5 with a full queue, then reset mid-stream.
    do_reset(1'b0);
    run_to(3); @(negedge clk);
    check("full_count", 32'(dut.count), 32'd2);
    check("full_fetch_pc", fetch_pc, 32'd2);
    run_to(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    push_exp(32'h8, 4);
    run_to(6);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    check("rd_c6_valid", 32'(out_valid), 32'd0);
    check("rd_c6_fetch_pc", fetch_pc, 32'h8);
    run_to(7); @(negedge clk); check("rd_c7_valid", 32'(out_valid), 32'd0);
    run_to(8); @(negedge clk);
    check("rd_c8_valid", 32'(out_valid), 32'd1);
    check("rd_c8_pc", out_pc, 32'h8);
    run_to(11);
    run_to(12);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h77;
    run_to(13); @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ins", out_ins, 32'h00000013);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_fetch_pc", fetch_pc, 32'h0);
    check("sb_drain_rst", 32'(exp_q.size()), 32'd0);

    // Redirect while the valid head is being accepted.
    do_reset(1'b1);
    push_exp(32'd0, 4);
    push_exp(32'h40, 4);
    run_to(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    run_to(6);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rdp_c6_valid", 32'(out_valid), 32'd0);
    check("rdp_c6_fetch_pc", fetch_pc, 32'h40);
    run_to(8); @(negedge clk); check("rdp_c8_pc", out_pc, 32'h40);
    run_to(11);
    finish_scn();

    // Back-to-back redirects: 4 in cycle 5, 9 in cycle 6.
    do_reset(1'b1);
    push_exp(32'd0, 4);
    push_exp(32'd9, 4);
    run_to(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    run_to(6);
    redirect_pc    = 32'd9;
    @(negedge clk);
    check("b2b_c6_fetch_pc", fetch_pc, 32'd4);
    check("b2b_c6_valid", 32'(out_valid), 32'd0);
    run_to(7);
    redirect_valid = 1'b0;
    @(negedge clk); check("b2b_c7_fetch_pc", fetch_pc, 32'd9);
    run_to(8); @(negedge clk); check("b2b_c8_valid", 32'(out_valid), 32'd0);
    run_to(9); @(negedge clk); check("b2b_c9_pc", out_pc, 32'd9);
    run_to(12);
    finish_scn();

    // PC wrap at the top of the address space.
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    exp_q.push_back('{pc: 32'hFFFF_FFFF, ins: ins_of(32'hFFFF_FFFF)});
    push_exp(32'd0, 3);
    run_to(1);
    redirect_valid = 1'b0;
    @(negedge clk); check("wrap_c1_fetch_pc", fetch_pc, 32'hFFFF_FFFF);
    run_to(2); @(negedge clk); check("wrap_c2_fetch_pc", fetch_pc, 32'h0);
    run_to(3); @(negedge clk); check("wrap_c3_pc", out_pc, 32'hFFFF_FFFF);
    run_to(4); @(negedge clk); check("wrap_c4_pc", out_pc, 32'h0);
    run_to(6);
    finish_scn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
